// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU operation sequencer.
// Used by the sequencer top and its control decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    OPB_RT,
    OPB_SEXT,
    OPB_ZEXT
  } opb_sel_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response bundle between register-read, sequencer and writeback.
// master = upstream/downstream side, slave = sequencer side.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_branch_taken;
  logic              rsp_illegal;

  modport master (
    output req_valid, instr, rs_data, rt_data,
    output flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_zero, rsp_branch_taken, rsp_illegal
  );

  modport slave (
    input  req_valid, instr, rs_data, rt_data,
    input  flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_zero, rsp_branch_taken, rsp_illegal
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode/funct decode into ALU control and operand selects.
// Unsupported encodings fall back to ADD with the illegal flag set.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] ctrl,
  output opb_sel_e   opb_sel,
  output logic       use_shamt,
  output logic       is_branch,
  output logic       is_bne,
  output logic       illegal
);

  always_comb begin
    ctrl      = ALU_ADD;
    opb_sel   = OPB_RT;
    use_shamt = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        use_shamt = 1'b1;
        unique case (funct)
          F_ADD, F_ADDU: ctrl = ALU_ADD;
          F_SUB, F_SUBU: ctrl = ALU_SUB;
          F_AND:         ctrl = ALU_AND;
          F_NOR:         ctrl = ALU_NOR;
          F_SLT:         ctrl = ALU_SLT;
          F_SLL:         ctrl = ALU_SLL;
          default: begin
            use_shamt = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      (op == OP_ADDI || op == OP_ADDIU ||
       op == OP_LW   || op == OP_SW): begin
        opb_sel = OPB_SEXT;
      end
      (op == OP_ANDI): begin
        ctrl    = ALU_AND;
        opb_sel = OPB_ZEXT;
      end
      (op == OP_SLTI): begin
        ctrl    = ALU_SLT;
        opb_sel = OPB_SEXT;
      end
      (op == OP_BEQ || op == OP_BNE): begin
        ctrl      = ALU_SUB;
        is_branch = 1'b1;
        is_bne    = (op == OP_BNE);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue stage: IDLE -> DECODE -> EXEC -> RESP around the ALU.
// Optional ALU_PERF_CNT_EN adds op_count / illegal_count outputs.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter bit HOLD_ON_ILLEGAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus,
  output logic [DATA_W-1:0] alu_opA,
  output logic [DATA_W-1:0] alu_opB,
  output logic [4:0]        alu_shamt,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]       op_count,
  output logic [31:0]       illegal_count
`endif
);

  seq_state_e        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [4:0]        shamt_q, shamt_d;
  logic              br_q, br_d;
  logic              bne_q, bne_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              zero_q, zero_d;
  logic              taken_q, taken_d;

  logic [2:0] dec_ctrl;
  opb_sel_e   dec_opb_sel;
  logic       dec_use_shamt;
  logic       dec_br;
  logic       dec_bne;
  logic       dec_ill;
  logic       res_zero;
  logic       rsp_done;
  logic       unused_instr;

  assign unused_instr = ^bus.instr[25:16];

  alu_ctrl_decode u_dec (
    .op        (op_q),
    .funct     (imm_q[5:0]),
    .ctrl      (dec_ctrl),
    .opb_sel   (dec_opb_sel),
    .use_shamt (dec_use_shamt),
    .is_branch (dec_br),
    .is_bne    (dec_bne),
    .illegal   (dec_ill)
  );

  assign res_zero = (alu_result == '0);

  // A held illegal response is released only by flush.
  assign rsp_done = (state_q == S_RESP) &&
                    ((HOLD_ON_ILLEGAL && ill_q) ? bus.flush
                                                : bus.rsp_ready);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    ctrl_d  = ctrl_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    shamt_d = shamt_q;
    br_d    = br_q;
    bne_d   = bne_q;
    ill_d   = ill_q;
    data_d  = data_q;
    zero_d  = zero_q;
    taken_d = taken_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.instr[31:26];
          imm_d   = bus.instr[15:0];
          rs_d    = bus.rs_data;
          rt_d    = bus.rt_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_d  = dec_ctrl;
        br_d    = dec_br;
        bne_d   = dec_bne;
        ill_d   = dec_ill;
        opa_d   = dec_ill ? '0 : rs_q;
        shamt_d = dec_use_shamt ? imm_q[10:6] : 5'd0;
        unique case (dec_opb_sel)
          OPB_SEXT: opb_d = {{(DATA_W-16){imm_q[15]}}, imm_q};
          OPB_ZEXT: opb_d = {{(DATA_W-16){1'b0}}, imm_q};
          default:  opb_d = rt_q;
        endcase
        if (dec_ill) opb_d = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        data_d  = ill_q ? '0 : alu_result;
        zero_d  = ~ill_q & res_zero;
        taken_d = br_q & (bne_q ^ res_zero);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      ctrl_q  <= ALU_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      shamt_q <= '0;
      br_q    <= 1'b0;
      bne_q   <= 1'b0;
      ill_q   <= 1'b0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      ctrl_q  <= ctrl_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      shamt_q <= shamt_d;
      br_q    <= br_d;
      bne_q   <= bne_d;
      ill_q   <= ill_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      taken_q <= taken_d;
    end
  end

  assign bus.req_ready        = (state_q == S_IDLE);
  assign bus.rsp_valid        = (state_q == S_RESP);
  assign bus.rsp_data         = data_q;
  assign bus.rsp_zero         = zero_q;
  assign bus.rsp_branch_taken = taken_q;
  assign bus.rsp_illegal      = ill_q;

  assign alu_opA   = opa_q;
  assign alu_opB   = opb_q;
  assign alu_shamt = shamt_q;
  assign alu_ctrl  = ctrl_q;

`ifdef ALU_PERF_CNT_EN
  logic [31:0] op_cnt_q, op_cnt_d;
  logic [31:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    op_cnt_d  = op_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (rsp_done) begin
      op_cnt_d = op_cnt_q + 32'd1;
      if (ill_q) ill_cnt_d = ill_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt_q  <= '0;
      ill_cnt_q <= '0;
    end else begin
      op_cnt_q  <= op_cnt_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign op_count      = op_cnt_q;
  assign illegal_count = ill_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU model.
// Covers both HOLD_ON_ILLEGAL settings and optional ALU_PERF_CNT_EN.
module tb_alu_op_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(W)) bus ();
  alu_op_sequencer_if #(.DATA_W(W)) hbus ();

  logic [W-1:0] a_opa, a_opb, a_res;
  logic [W-1:0] h_opa, h_opb, h_res;
  logic [4:0]   a_sh, h_sh;
  logic [2:0]   a_ctrl, h_ctrl;
`ifdef ALU_PERF_CNT_EN
  logic [31:0] a_opc, a_illc, h_opc, h_illc;
`endif

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] alu_f(
    input logic [2:0] c, input logic [31:0] a, b,
    input logic [4:0] s);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return b << s;
      3'b011:  return ~(a | b);
      3'b100:  return a & b;
      3'b101:  return {31'b0, $signed(a) < $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  assign a_res = alu_f(a_ctrl, a_opa, a_opb, a_sh);
  assign h_res = alu_f(h_ctrl, h_opa, h_opb, h_sh);

  alu_op_sequencer #(.DATA_W(W), .HOLD_ON_ILLEGAL(1'b0)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .alu_opA       (a_opa),
    .alu_opB       (a_opb),
    .alu_shamt     (a_sh),
    .alu_ctrl      (a_ctrl),
`ifdef ALU_PERF_CNT_EN
    .op_count      (a_opc),
    .illegal_count (a_illc),
`endif
    .alu_result    (a_res)
  );

  alu_op_sequencer #(.DATA_W(W), .HOLD_ON_ILLEGAL(1'b1)) u_hold (
    .clk           (clk),
    .rst           (rst),
    .bus           (hbus.slave),
    .alu_opA       (h_opa),
    .alu_opB       (h_opb),
    .alu_shamt     (h_sh),
    .alu_ctrl      (h_ctrl),
`ifdef ALU_PERF_CNT_EN
    .op_count      (h_opc),
    .illegal_count (h_illc),
`endif
    .alu_result    (h_res)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string tag, input logic [31:0] i, a, b,
    input logic [2:0] ec, input logic [31:0] ea, eb,
    input logic csh, input logic [4:0] esh,
    input logic [31:0] ed, input logic ez, ebr, eill,
    input int stall);
    int n;
    @(negedge clk);
    bus.instr     = i;
    bus.rs_data   = a;
    bus.rt_data   = b;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".acc"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, ".v_dec"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".ctrl"}, 32'(a_ctrl), 32'(ec));
    chk({tag, ".opA"}, a_opa, ea);
    chk({tag, ".opB"}, a_opb, eb);
    if (csh) chk({tag, ".sh"}, 32'(a_sh), 32'(esh));
    chk({tag, ".v_ex"}, 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".data"}, bus.rsp_data, ed);
    chk({tag, ".zero"}, 32'(bus.rsp_zero), 32'(ez));
    chk({tag, ".br"}, 32'(bus.rsp_branch_taken), 32'(ebr));
    chk({tag, ".ill"}, 32'(bus.rsp_illegal), 32'(eill));
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, ".st_v"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".st_d"}, bus.rsp_data, ed);
      chk({tag, ".st_z"}, 32'(bus.rsp_zero), 32'(ez));
      chk({tag, ".st_rdy"}, 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({tag, ".done_v"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".done_rdy"}, 32'(bus.req_ready), 32'd1);
    chk({tag, ".idle_ctrl"}, 32'(a_ctrl), 32'(ec));
    chk({tag, ".idle_opB"}, a_opb, eb);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.instr = '0;
    bus.rs_data = '0; bus.rt_data = '0;
    bus.flush = 1'b0; bus.rsp_ready = 1'b0;
    hbus.req_valid = 1'b0; hbus.instr = '0;
    hbus.rs_data = '0; hbus.rt_data = '0;
    hbus.flush = 1'b0; hbus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(bus.req_ready), 32'd1);
    chk("rst.v", 32'(bus.rsp_valid), 32'd0);
    chk("rst.ctrl", 32'(a_ctrl), 32'd0);
    chk("rst.opA", a_opa, 32'd0);
    chk("rst.data", bus.rsp_data, 32'd0);
    chk("rst.ill", 32'(bus.rsp_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //     tag     instr         rs            rt
    //     ctrl  opA  opB  csh sh  data  z br ill stall
    run_op("add", 32'h00221820, 32'd5, 32'd7,
           3'b000, 32'd5, 32'd7, 1, 5'd0,
           32'd12, 0, 0, 0, 0);
    run_op("beq", 32'h10220010, 32'h1234, 32'h1234,
           3'b001, 32'h1234, 32'h1234, 0, 5'd0,
           32'd0, 1, 1, 0, 0);
    run_op("bne", 32'h14220010, 32'h1234, 32'h1234,
           3'b001, 32'h1234, 32'h1234, 0, 5'd0,
           32'd0, 1, 0, 0, 0);
    run_op("addi", 32'h2022FFFF, 32'd1, 32'd9,
           3'b000, 32'd1, 32'hFFFFFFFF, 0, 5'd0,
           32'd0, 1, 0, 0, 0);
    run_op("andi", 32'h30228001, 32'hFFFFFFFF, 32'd9,
           3'b100, 32'hFFFFFFFF, 32'h00008001, 0, 5'd0,
           32'h00008001, 0, 0, 0, 0);
    run_op("sll", 32'h00021900, 32'd0, 32'h0F,
           3'b010, 32'd0, 32'h0F, 1, 5'd4,
           32'hF0, 0, 0, 0, 5);
    run_op("sub", 32'h00221822, 32'd3, 32'd5,
           3'b001, 32'd3, 32'd5, 1, 5'd0,
           32'hFFFFFFFE, 0, 0, 0, 0);
    run_op("slt", 32'h0022182A, 32'hFFFFFFFF, 32'd1,
           3'b101, 32'hFFFFFFFF, 32'd1, 1, 5'd0,
           32'd1, 0, 0, 0, 0);
    run_op("nor", 32'h00221827, 32'd0, 32'd0,
           3'b011, 32'd0, 32'd0, 1, 5'd0,
           32'hFFFFFFFF, 0, 0, 0, 0);
    run_op("slti", 32'h28220005, 32'hFFFFFFFD, 32'd9,
           3'b101, 32'hFFFFFFFD, 32'd5, 0, 5'd0,
           32'd1, 0, 0, 0, 0);
    run_op("ill", 32'hFC000000, 32'd5, 32'd7,
           3'b000, 32'd0, 32'd0, 0, 5'd0,
           32'd0, 0, 0, 1, 0);
`ifdef ALU_PERF_CNT_EN
    chk("perf.ops", a_opc, 32'd11);
    chk("perf.ill", a_illc, 32'd1);
`endif

    // held illegal response on the HOLD_ON_ILLEGAL=1 instance
    @(negedge clk);
    hbus.instr = 32'hFC000000;
    hbus.rs_data = 32'd5;
    hbus.rt_data = 32'd7;
    hbus.req_valid = 1'b1;
    hbus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    hbus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold.v", 32'(hbus.rsp_valid), 32'd1);
    chk("hold.ill", 32'(hbus.rsp_illegal), 32'd1);
    chk("hold.data", hbus.rsp_data, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold.stay", 32'(hbus.rsp_valid), 32'd1);
    end
    @(negedge clk);
    hbus.flush = 1'b1;
    @(posedge clk); #1;
    hbus.flush = 1'b0;
    chk("hold.flush_v", 32'(hbus.rsp_valid), 32'd0);
    chk("hold.flush_rdy", 32'(hbus.req_ready), 32'd1);

    // reset while the main instance is in EXEC
    @(negedge clk);
    bus.instr = 32'h00221820;
    bus.rs_data = 32'd5;
    bus.rt_data = 32'd7;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rx.exec_opA", a_opa, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rx.rdy", 32'(bus.req_ready), 32'd1);
    chk("rx.v", 32'(bus.rsp_valid), 32'd0);
    chk("rx.opA", a_opa, 32'd0);
    chk("rx.opB", a_opb, 32'd0);
`ifdef ALU_PERF_CNT_EN
    chk("rx.perf_ops", a_opc, 32'd0);
    chk("rx.perf_ill", a_illc, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rx.no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
